// File: rtl/proto_msg_stack_ctrl.sv
// Nested protobuf message stack sequencer: tracks {id, end offset} per level and drives the ROM node index.
// Optional statistics outputs (msg_count, max_depth) are enabled by defining PROTO_STACK_STATS_EN.
module proto_msg_stack_ctrl #(
    parameter int NUM_MSG_HIERARCHY = 2,
    parameter int NUM_MSGS          = 2,
    parameter int IDENTIFIER_SIZE   = 4,
    parameter int LEN_W             = 16,
    localparam int DEPTH_W = $clog2(NUM_MSG_HIERARCHY + 1),
    localparam int NODE_W  = $clog2(NUM_MSGS + 1),
    localparam int PATH_W  = NUM_MSG_HIERARCHY * IDENTIFIER_SIZE,
    parameter logic [PATH_W-1:0] DEPENDENCIES [NUM_MSGS] = '{8'h01, 8'h41}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_valid,
    input  logic [LEN_W-1:0]           start_len,
    input  logic                       byte_valid,
    output logic                       byte_ready,
    input  logic                       push_valid,
    input  logic [IDENTIFIER_SIZE-1:0] push_id,
    input  logic [LEN_W-1:0]           push_len,
    output logic                       push_ready,
    output logic [DEPTH_W-1:0]         depth,
    output logic [PATH_W-1:0]          path,
    output logic [NODE_W-1:0]          node_idx,
    output logic                       msg_end,
    output logic [IDENTIFIER_SIZE-1:0] msg_end_id,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code
`ifdef PROTO_STACK_STATS_EN
    ,
    output logic [15:0]                msg_count,
    output logic [DEPTH_W-1:0]         max_depth
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_POP, S_ERR} state_t;

    state_t                     state_q, state_d;
    logic [LEN_W-1:0]           cnt_q, cnt_d;
    logic [LEN_W-1:0]           root_end_q, root_end_d;
    logic [DEPTH_W-1:0]         depth_q, depth_d;
    logic [PATH_W-1:0]          path_q, path_d;
    logic [LEN_W-1:0]           end_q [NUM_MSG_HIERARCHY];
    logic [LEN_W-1:0]           end_d [NUM_MSG_HIERARCHY];
    logic [NODE_W-1:0]          node_idx_q, node_idx_d;
    logic                       err_q, err_d;
    logic [1:0]                 err_code_q, err_code_d;

    logic [LEN_W-1:0]           top_end, pop_end;
    logic [IDENTIFIER_SIZE-1:0] top_id;
    logic [LEN_W:0]             new_end;
    logic                       check_path, path_known;
    logic [NODE_W-1:0]          node_hit;

    // End offset and id of the innermost open level; root end when nothing is pushed.
    always_comb begin
        top_end = root_end_q;
        top_id  = '0;
        for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
            if (depth_q == DEPTH_W'(i + 1)) begin
                top_end = end_q[i];
                top_id  = path_q[i*IDENTIFIER_SIZE +: IDENTIFIER_SIZE];
            end
        end
    end

    assign new_end = {1'b0, cnt_q} + {1'b0, push_len};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        root_end_d = root_end_q;
        depth_d    = depth_q;
        path_d     = path_q;
        end_d      = end_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        byte_ready = 1'b0;
        push_ready = 1'b0;
        msg_end    = 1'b0;
        msg_end_id = '0;
        done       = 1'b0;
        check_path = 1'b0;
        pop_end    = root_end_q;

        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    root_end_d = start_len;
                    cnt_d      = '0;
                    depth_d    = '0;
                    path_d     = '0;
                    state_d    = (start_len == '0) ? S_POP : S_RUN;
                end
            end
            S_RUN: begin
                push_ready = 1'b1;
                byte_ready = !push_valid;
                if (push_valid) begin
                    if (new_end > {1'b0, top_end}) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                    end else if (depth_q == DEPTH_W'(NUM_MSG_HIERARCHY)) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                    end else begin
                        for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
                            if (depth_q == DEPTH_W'(i)) begin
                                end_d[i] = new_end[LEN_W-1:0];
                                path_d[i*IDENTIFIER_SIZE +: IDENTIFIER_SIZE] = push_id;
                            end
                        end
                        depth_d    = depth_q + 1'b1;
                        check_path = 1'b1;
                        if (push_len == '0) state_d = S_POP;
                    end
                end else if (byte_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == top_end) state_d = S_POP;
                end
            end
            S_POP: begin
                if (depth_q != '0) begin
                    msg_end    = 1'b1;
                    msg_end_id = top_id;
                    depth_d    = depth_q - 1'b1;
                    for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
                        if (depth_q == DEPTH_W'(i + 1))
                            path_d[i*IDENTIFIER_SIZE +: IDENTIFIER_SIZE] = '0;
                        if (depth_d == DEPTH_W'(i + 1))
                            pop_end = end_q[i];
                    end
                    // Parents ending at the same offset unwind one level per cycle.
                    state_d = (cnt_q == pop_end) ? S_POP : S_RUN;
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        path_known = 1'b0;
        node_hit   = '0;
        for (int k = 0; k < NUM_MSGS; k++) begin
            if (path_d == DEPENDENCIES[k]) begin
                path_known = 1'b1;
                node_hit   = NODE_W'(k + 1);
            end
        end
        node_idx_d = node_idx_q;
        if (depth_d == '0) begin
            node_idx_d = '0;
        end else if (path_known) begin
            node_idx_d = node_hit;
        end else if (check_path) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            root_end_q <= '0;
            depth_q    <= '0;
            path_q     <= '0;
            end_q      <= '{default: '0};
            node_idx_q <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            root_end_q <= root_end_d;
            depth_q    <= depth_d;
            path_q     <= path_d;
            end_q      <= end_d;
            node_idx_q <= node_idx_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign depth    = depth_q;
    assign path     = path_q;
    assign node_idx = node_idx_q;
    assign err      = err_q;
    assign err_code = err_code_q;

`ifdef PROTO_STACK_STATS_EN
    logic [15:0]        msg_count_q, msg_count_d;
    logic [DEPTH_W-1:0] max_depth_q, max_depth_d;

    always_comb begin
        msg_count_d = msg_count_q;
        max_depth_d = max_depth_q;
        if (state_q == S_IDLE && start_valid) begin
            msg_count_d = '0;
            max_depth_d = '0;
        end else begin
            if (msg_end && msg_count_q != 16'hFFFF) msg_count_d = msg_count_q + 16'd1;
            if (depth_d > max_depth_q) max_depth_d = depth_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msg_count_q <= '0;
            max_depth_q <= '0;
        end else begin
            msg_count_q <= msg_count_d;
            max_depth_q <= max_depth_d;
        end
    end

    assign msg_count = msg_count_q;
    assign max_depth = max_depth_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_proto_msg_stack_ctrl.sv
// Self-checking bench for proto_msg_stack_ctrl: directed vector table, corner sequences, random vs queue model.
module tb_proto_msg_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic [15:0] start_len;
    logic        byte_valid;
    logic        byte_ready;
    logic        push_valid;
    logic [3:0]  push_id;
    logic [15:0] push_len;
    logic        push_ready;
    logic [1:0]  depth;
    logic [7:0]  path;
    logic [1:0]  node_idx;
    logic        msg_end;
    logic [3:0]  msg_end_id;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
`ifdef PROTO_STACK_STATS_EN
    logic [15:0] msg_count;
    logic [1:0]  max_depth;
`endif

    proto_msg_stack_ctrl dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_len(start_len),
        .byte_valid(byte_valid), .byte_ready(byte_ready),
        .push_valid(push_valid), .push_id(push_id), .push_len(push_len), .push_ready(push_ready),
        .depth(depth), .path(path), .node_idx(node_idx),
        .msg_end(msg_end), .msg_end_id(msg_end_id), .done(done),
        .err(err), .err_code(err_code)
`ifdef PROTO_STACK_STATS_EN
        , .msg_count(msg_count), .max_depth(max_depth)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: stack of {id, end} as queues ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_POP = 2, M_ERR = 3;
    int m_mode, m_cnt, m_root, m_err, m_code;
    int stk_id[$];
    int stk_end[$];
    bit model_valid = 0;

    // Known hierarchy paths: [1] -> node 1, [1,4] -> node 2.
    function automatic int m_node();
        if (stk_id.size() == 0) return 0;
        if (stk_id.size() == 1 && stk_id[0] == 1) return 1;
        if (stk_id.size() == 2 && stk_id[0] == 1 && stk_id[1] == 4) return 2;
        return -1;
    endfunction

    function automatic int m_top();
        return (stk_end.size() > 0) ? stk_end[stk_end.size()-1] : m_root;
    endfunction

    function automatic int m_path();
        int p = 0;
        foreach (stk_id[i]) p += stk_id[i] << (4 * i);
        return p;
    endfunction

    task automatic model_check();
        int nd;
        chk("model byte_ready", 32'(byte_ready), 32'(m_mode == M_RUN && !push_valid));
        chk("model push_ready", 32'(push_ready), 32'(m_mode == M_RUN));
        chk("model msg_end", 32'(msg_end), 32'(m_mode == M_POP && stk_id.size() > 0));
        chk("model msg_end_id", 32'(msg_end_id),
            (m_mode == M_POP && stk_id.size() > 0) ? 32'(stk_id[stk_id.size()-1]) : 32'd0);
        chk("model done", 32'(done), 32'(m_mode == M_POP && stk_id.size() == 0));
        chk("model depth", 32'(depth), 32'(stk_id.size()));
        chk("model path", 32'(path), 32'(m_path()));
        chk("model err", 32'(err), 32'(m_err));
        chk("model err_code", 32'(err_code), 32'(m_code));
        nd = m_node();
        if (m_mode != M_ERR) chk("model node_idx", 32'(node_idx), 32'(nd));
    endtask

    task automatic model_step();
        int ne;
        if (rst) begin
            m_mode = M_IDLE; m_cnt = 0; m_root = 0; m_err = 0; m_code = 0;
            stk_id.delete(); stk_end.delete();
            model_valid = 1;
            return;
        end
        case (m_mode)
            M_IDLE: if (start_valid) begin
                m_root = int'(start_len); m_cnt = 0;
                stk_id.delete(); stk_end.delete();
                m_mode = (start_len == 0) ? M_POP : M_RUN;
            end
            M_RUN: begin
                if (push_valid) begin
                    ne = m_cnt + int'(push_len);
                    if (ne > m_top()) begin
                        m_mode = M_ERR; m_err = 1; m_code = 2;
                    end else if (stk_id.size() == 2) begin
                        m_mode = M_ERR; m_err = 1; m_code = 1;
                    end else begin
                        stk_id.push_back(int'(push_id));
                        stk_end.push_back(ne);
                        if (m_node() < 0) begin
                            m_mode = M_ERR; m_err = 1; m_code = 3;
                        end else if (push_len == 0) begin
                            m_mode = M_POP;
                        end
                    end
                end else if (byte_valid) begin
                    m_cnt++;
                    if (m_cnt == m_top()) m_mode = M_POP;
                end
            end
            M_POP: begin
                if (stk_id.size() > 0) begin
                    void'(stk_id.pop_back());
                    void'(stk_end.pop_back());
                    m_mode = (m_cnt == m_top()) ? M_POP : M_RUN;
                end else begin
                    m_mode = M_IDLE;
                end
            end
            default: ;
        endcase
    endtask

    // One clock: check against model mid-cycle, step model at the edge, return at next negedge.
    task automatic cycle();
        #1;
        if (model_valid) model_check();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_in(input logic r, input logic sv, input int sl, input logic bv,
                          input logic pv, input int pid, input int plen);
        rst = r; start_valid = sv; start_len = 16'(sl); byte_valid = bv;
        push_valid = pv; push_id = 4'(pid); push_len = 16'(plen);
    endtask

    task automatic idle();   set_in(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_reset(); set_in(1, 0, 0, 0, 0, 0, 0); cycle(); idle(); endtask
    task automatic start(input int len); set_in(0, 1, len, 0, 0, 0, 0); cycle(); endtask
    task automatic bytes(input int n);
        for (int i = 0; i < n; i++) begin set_in(0, 0, 0, 1, 0, 0, 0); cycle(); end
    endtask
    task automatic push(input int id, input int len); set_in(0, 0, 0, 0, 1, id, len); cycle(); endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r, sv;
        logic [15:0] sl;
        logic        bv, pv;
        logic [3:0]  pid;
        logic [15:0] plen;
        logic [1:0]  e_depth;
        logic [7:0]  e_path;
        logic [1:0]  e_node;
        logic        e_me;
        logic [3:0]  e_meid;
        logic        e_done, e_err;
        logic [1:0]  e_code;
        logic        e_br, e_pr;
    } vec_t;

    vec_t vt[17];

    initial begin
        int pidx;
        int err_run;
        idle();
        rst = 1'b1;
        @(negedge clk);

        //            r  sv sl  bv pv id len  dep path   nd me id dn er cd br pr
        vt[0]  = '{0, 1, 10, 0, 0, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 0, 0,  1, 0, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[2]  = '{0, 0, 0,  1, 0, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[3]  = '{0, 0, 0,  0, 1, 1, 6,   0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1};
        vt[4]  = '{0, 0, 0,  1, 0, 0, 0,   1, 8'h01, 1, 0, 0, 0, 0, 0, 1, 1};
        vt[5]  = '{0, 0, 0,  1, 0, 0, 0,   1, 8'h01, 1, 0, 0, 0, 0, 0, 1, 1};
        vt[6]  = '{0, 0, 0,  0, 1, 4, 4,   1, 8'h01, 1, 0, 0, 0, 0, 0, 0, 1};
        vt[7]  = '{0, 0, 0,  1, 0, 0, 0,   2, 8'h41, 2, 0, 0, 0, 0, 0, 1, 1};
        vt[8]  = '{0, 0, 0,  1, 0, 0, 0,   2, 8'h41, 2, 0, 0, 0, 0, 0, 1, 1};
        vt[9]  = '{0, 0, 0,  1, 0, 0, 0,   2, 8'h41, 2, 0, 0, 0, 0, 0, 1, 1};
        vt[10] = '{0, 0, 0,  1, 0, 0, 0,   2, 8'h41, 2, 0, 0, 0, 0, 0, 1, 1};
        vt[11] = '{0, 0, 0,  1, 0, 0, 0,   2, 8'h41, 2, 1, 4, 0, 0, 0, 0, 0};
        vt[12] = '{0, 0, 0,  0, 0, 0, 0,   1, 8'h01, 1, 1, 1, 0, 0, 0, 0, 0};
        vt[13] = '{0, 0, 0,  1, 0, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[14] = '{0, 0, 0,  1, 0, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[15] = '{0, 0, 0,  0, 0, 0, 0,   0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0};
        vt[16] = '{0, 0, 0,  0, 0, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0};

        do_reset();
        #1;
        chk("reset depth", 32'(depth), 0);
        chk("reset node_idx", 32'(node_idx), 0);
        chk("reset err", 32'(err), 0);
        chk("reset byte_ready", 32'(byte_ready), 0);

        for (int i = 0; i < 17; i++) begin
            set_in(vt[i].r, vt[i].sv, int'(vt[i].sl), vt[i].bv, vt[i].pv, int'(vt[i].pid), int'(vt[i].plen));
            #1;
            chk($sformatf("vec%0d depth", i), 32'(depth), 32'(vt[i].e_depth));
            chk($sformatf("vec%0d path", i), 32'(path), 32'(vt[i].e_path));
            chk($sformatf("vec%0d node_idx", i), 32'(node_idx), 32'(vt[i].e_node));
            chk($sformatf("vec%0d msg_end", i), 32'(msg_end), 32'(vt[i].e_me));
            chk($sformatf("vec%0d msg_end_id", i), 32'(msg_end_id), 32'(vt[i].e_meid));
            chk($sformatf("vec%0d done", i), 32'(done), 32'(vt[i].e_done));
            chk($sformatf("vec%0d err", i), 32'(err), 32'(vt[i].e_err));
            chk($sformatf("vec%0d err_code", i), 32'(err_code), 32'(vt[i].e_code));
            chk($sformatf("vec%0d byte_ready", i), 32'(byte_ready), 32'(vt[i].e_br));
            chk($sformatf("vec%0d push_ready", i), 32'(push_ready), 32'(vt[i].e_pr));
            cycle();
        end

        // Zero-length top-level message.
        do_reset();
        start(0);
        idle(); #1 chk("zero_start done", 32'(done), 1);
        cycle();
        #1 chk("zero_start done clears", 32'(done), 0);

        // Zero-length embedded message leaves cnt untouched.
        do_reset();
        start(5);
        push(1, 0);
        idle(); #1;
        chk("zero_push depth", 32'(depth), 1);
        chk("zero_push msg_end", 32'(msg_end), 1);
        chk("zero_push msg_end_id", 32'(msg_end_id), 1);
        cycle();
        #1;
        chk("zero_push back depth", 32'(depth), 0);
        chk("zero_push back run", 32'(byte_ready), 1);
        bytes(5);
        idle(); #1 chk("zero_push root done", 32'(done), 1);
        cycle();

        // Depth overflow.
        do_reset();
        start(10);
        push(1, 6);
        push(4, 4);
        push(2, 1);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 3, 1, 0, 0, 0); #1;
            chk("overflow err", 32'(err), 1);
            chk("overflow err_code", 32'(err_code), 1);
            chk("overflow byte_ready", 32'(byte_ready), 0);
            cycle();
        end
        do_reset(); #1;
        chk("overflow cleared err", 32'(err), 0);

        // Child longer than parent.
        do_reset();
        start(5);
        bytes(2);
        push(1, 4);
        idle(); #1 chk("len_violation err_code", 32'(err_code), 2);
        cycle();

        // Unknown hierarchy path.
        do_reset();
        start(5);
        push(3, 2);
        idle(); #1;
        chk("unknown err", 32'(err), 1);
        chk("unknown err_code", 32'(err_code), 3);
        cycle();

        // Push and byte together: push wins.
        do_reset();
        start(5);
        set_in(0, 0, 0, 1, 1, 1, 2); #1;
        chk("contend byte_ready", 32'(byte_ready), 0);
        chk("contend push_ready", 32'(push_ready), 1);
        cycle();
        bytes(2);
        idle(); #1 chk("contend pop after 2 bytes", 32'(msg_end), 1);
        cycle();

        // Reset while popping.
        do_reset();
        start(5);
        push(1, 0);
        set_in(1, 0, 0, 0, 0, 0, 0); #1;
        chk("rst_pop msg_end before rst", 32'(msg_end), 1);
        cycle();
        idle(); #1;
        chk("rst_pop depth", 32'(depth), 0);
        chk("rst_pop done", 32'(done), 0);
        chk("rst_pop push_ready", 32'(push_ready), 0);
        cycle();
        #1 chk("rst_pop no done later", 32'(done), 0);

        // Randomized traffic against the queue model.
        do_reset();
        err_run = 0;
        for (int c = 0; c < 3000; c++) begin
            pidx = $urandom_range(0, 9);
            set_in($urandom_range(0, 99) == 0 || err_run > 3,
                   1'($urandom_range(0, 1)),
                   $urandom_range(0, 24),
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 5) == 0,
                   (pidx < 4) ? 1 : (pidx < 8) ? 4 : (pidx == 8) ? 2 : 3,
                   $urandom_range(0, 10));
            cycle();
            err_run = (m_mode == M_ERR) ? err_run + 1 : 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
